// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared types and constants for the program-counter unit
package pc_pkg;

  // Branch condition codes as carried in the instruction's cond field
  typedef enum logic [2:0] {
    NEQ    = 3'b000,
    EQ     = 3'b001,
    GT     = 3'b010,
    LT     = 3'b011,
    GTE    = 3'b100,
    LTE    = 3'b101,
    OVFL   = 3'b110,
    UNCOND = 3'b111
  } cond_e;

  // Bit positions inside the flags vector
  localparam int FLAG_N = 0;
  localparam int FLAG_V = 1;
  localparam int FLAG_Z = 2;

  // Sequencer state: HALTED is left only through reset
  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } pc_state_e;

endpackage

// File: rtl/pc_seq_unit_branch_cond_eval.sv
// rtl/pc_seq_unit_branch_cond_eval.sv - combinational branch condition evaluator
module branch_cond_eval
  import pc_pkg::*;
(
  input  logic [2:0] cond,
  input  logic [2:0] flags,
  output logic       cond_true
);

  logic z;
  logic v;
  logic n;

  assign z = flags[FLAG_Z];
  assign v = flags[FLAG_V];
  assign n = flags[FLAG_N];

  // Decode the condition code against the current Z/V/N flags
  always_comb begin
    cond_true = 1'b0;
    case (cond_e'(cond))
      NEQ:     cond_true = !z;
      EQ:      cond_true = z;
      GT:      cond_true = !z && !n;
      LT:      cond_true = n;
      GTE:     cond_true = z || (!z && !n);
      LTE:     cond_true = n || z;
      OVFL:    cond_true = v;
      UNCOND:  cond_true = 1'b1;
      default: cond_true = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_seq_unit.sv
// rtl/pc_seq_unit.sv - registered PC with branch, stall, halt and flush; optional PC_BRANCH_STATS_EN counters
module pc_seq_unit
  import pc_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int IMM_W      = 9,
  parameter int INSN_BYTES = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              halt,
  input  logic              br_valid,
  input  logic              br_reg,
  input  logic [2:0]        cond,
  input  logic [2:0]        flags,
  input  logic [IMM_W-1:0]  imm,
  input  logic [ADDR_W-1:0] rs_val,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus,
  output logic              taken,
  output logic              flush,
  output logic              halted
`ifdef PC_BRANCH_STATS_EN
  ,
  output logic [ADDR_W-1:0] br_count,
  output logic [ADDR_W-1:0] taken_count
`endif
);

  pc_state_e         state;
  logic              cond_true;
  logic [ADDR_W-1:0] offset;
  logic [ADDR_W-1:0] target;

  branch_cond_eval u_cond (
    .cond      (cond),
    .flags     (flags),
    .cond_true (cond_true)
  );

  assign pc_plus = pc + ADDR_W'(INSN_BYTES);

  // Word offset sign-extended to the address width; the shift turns words into bytes
  assign offset = {{(ADDR_W-IMM_W){imm[IMM_W-1]}}, imm};
  assign target = br_reg ? rs_val : (pc_plus + (offset << 1));

  assign taken = (state == RUN) && !stall && !halt && br_valid && cond_true;

  // PC, run/halt state and the flush pulse, in next-PC priority order
  always_ff @(posedge clk) begin
    if (rst) begin
      pc     <= RESET_PC;
      state  <= RUN;
      flush  <= 1'b0;
      halted <= 1'b0;
    end else if (state == HALTED || stall) begin
      flush  <= 1'b0;
    end else if (halt) begin
      state  <= HALTED;
      halted <= 1'b1;
      flush  <= 1'b0;
    end else if (taken) begin
      pc     <= target;
      flush  <= 1'b1;
    end else begin
      pc     <= pc_plus;
      flush  <= 1'b0;
    end
  end

`ifdef PC_BRANCH_STATS_EN
  // Branch and taken-branch event counters, frozen once halted
  always_ff @(posedge clk) begin
    if (rst) begin
      br_count    <= '0;
      taken_count <= '0;
    end else begin
      if (state == RUN && !stall && br_valid) begin
        br_count <= br_count + 1'b1;
      end
      if (taken) begin
        taken_count <= taken_count + 1'b1;
      end
    end
  end
`else
  // Statistics counters are not built in this configuration
`endif

endmodule

// File: tb/tb_pc_seq_unit.sv
// tb/tb_pc_seq_unit.sv - directed self-checking bench for pc_seq_unit
module tb_pc_seq_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        halt;
  logic        br_valid;
  logic        br_reg;
  logic [2:0]  cond;
  logic [2:0]  flags;
  logic [8:0]  imm;
  logic [15:0] rs_val;
  logic [15:0] pc;
  logic [15:0] pc_plus;
  logic        taken;
  logic        flush;
  logic        halted;
`ifdef PC_BRANCH_STATS_EN
  logic [15:0] br_count;
  logic [15:0] taken_count;
`endif

  int checks   = 0;
  int failures = 0;

  pc_seq_unit dut (
    .clk      (clk),
    .rst      (rst),
    .stall    (stall),
    .halt     (halt),
    .br_valid (br_valid),
    .br_reg   (br_reg),
    .cond     (cond),
    .flags    (flags),
    .imm      (imm),
    .rs_val   (rs_val),
    .pc       (pc),
    .pc_plus  (pc_plus),
    .taken    (taken),
    .flush    (flush),
    .halted   (halted)
`ifdef PC_BRANCH_STATS_EN
    ,
    .br_count    (br_count),
    .taken_count (taken_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    stall = 0; halt = 0; br_valid = 0; br_reg = 0;
    cond = 3'd0; flags = 3'd0; imm = 9'd0; rs_val = 16'd0;
  endtask

  task automatic jump_br(input logic [15:0] dest);
    idle();
    br_valid = 1; br_reg = 1; cond = 3'b111; rs_val = dest;
    tick();
    idle();
  endtask

  initial begin
    idle();
    rst = 1;
    tick();
    tick();
    rst = 0;
    check("reset_pc", pc, 16'h0000);
    check("reset_halted", halted, 1'b0);
    check("reset_flush", flush, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      tick();
      check($sformatf("idle_pc_%0d", i), pc, 16'(2 * i));
    end
    check("idle_flush", flush, 1'b0);

    jump_br(16'h0010);
    check("br_to_10", pc, 16'h0010);

    // B EQ with Z=1, offset -2 words: 0x12 - 4 = 0x0E
    br_valid = 1; cond = 3'b001; flags = 3'b100; imm = 9'h1FE;
    #1;
    check("b_eq_taken", taken, 1'b1);
    tick();
    idle();
    check("b_eq_pc", pc, 16'h000E);
    check("b_eq_flush", flush, 1'b1);
    tick();
    check("flush_one_cycle", flush, 1'b0);
    check("pc_after_flush", pc, 16'h0010);

    // B NEQ with Z=1 is not taken
    br_valid = 1; cond = 3'b000; flags = 3'b100; imm = 9'h1FE;
    #1;
    check("b_neq_taken", taken, 1'b0);
    tick();
    idle();
    check("b_neq_pc", pc, 16'h0012);
    check("b_neq_flush", flush, 1'b0);

    // Unconditional B with flags=0, +4 words from 0x14 -> 0x1C
    br_valid = 1; cond = 3'b111; flags = 3'b000; imm = 9'd4;
    #1;
    check("b_always_taken", taken, 1'b1);
    tick();
    idle();
    check("b_always_pc", pc, 16'h001C);

    // A few more condition codes, evaluated without committing
    br_valid = 1; cond = 3'b010; flags = 3'b000;
    #1; check("gt_clear", taken, 1'b1);
    flags = 3'b001;
    #1; check("gt_neg", taken, 1'b0);
    cond = 3'b011;
    #1; check("lt_neg", taken, 1'b1);
    cond = 3'b100; flags = 3'b001;
    #1; check("gte_neg", taken, 1'b0);
    cond = 3'b101; flags = 3'b100;
    #1; check("lte_zero", taken, 1'b1);
    cond = 3'b110; flags = 3'b000;
    #1; check("ovfl_clear", taken, 1'b0);
    flags = 3'b010;
    #1; check("ovfl_set", taken, 1'b1);
    idle();

    // BR to 0xBEEF under stall: held, not taken
    br_valid = 1; br_reg = 1; cond = 3'b111; rs_val = 16'hBEEF; stall = 1;
    #1;
    check("br_stall_taken", taken, 1'b0);
    tick();
    check("br_stall_pc", pc, 16'h001C);
    check("br_stall_flush", flush, 1'b0);
    stall = 0;
    #1;
    check("br_taken", taken, 1'b1);
    tick();
    idle();
    check("br_pc", pc, 16'hBEEF);
    check("br_flush", flush, 1'b1);

    // Increment wraps at the top of the address space
    jump_br(16'hFFFE);
    check("pc_fffe", pc, 16'hFFFE);
    check("pc_plus_wrap", pc_plus, 16'h0000);
    tick();
    check("pc_wrap", pc, 16'h0000);

    // Negative offset below zero wraps: 0x0002 - 8 = 0xFFFA
    br_valid = 1; cond = 3'b111; imm = 9'h1FC;
    tick();
    idle();
    check("neg_wrap", pc, 16'hFFFA);

    jump_br(16'h0040);
    // stall together with halt: halt ignored
    stall = 1; halt = 1;
    tick();
    check("stall_halt_halted", halted, 1'b0);
    check("stall_halt_pc", pc, 16'h0040);
    // halt with an unconditional branch: halt wins
    stall = 0; br_valid = 1; cond = 3'b111; br_reg = 1; rs_val = 16'h1234;
    #1;
    check("halt_br_taken", taken, 1'b0);
    tick();
    idle();
    check("halt_halted", halted, 1'b1);
    check("halt_pc", pc, 16'h0040);
    br_valid = 1; cond = 3'b111;
    #1;
    check("halted_taken", taken, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("halted_pc_%0d", i), pc, 16'h0040);
    end
    check("halted_sticky", halted, 1'b1);
    check("halted_flush", flush, 1'b0);
    idle();
    rst = 1; halt = 1; stall = 1;
    tick();
    rst = 0;
    idle();
    check("rerst_pc", pc, 16'h0000);
    check("rerst_halted", halted, 1'b0);

`ifdef PC_BRANCH_STATS_EN
    check("stats_reset_br", br_count, 16'd0);
    check("stats_reset_taken", taken_count, 16'd0);
    br_valid = 1; cond = 3'b111;
    tick();
    cond = 3'b001; flags = 3'b000;
    tick();
    cond = 3'b111; stall = 1;
    tick();
    stall = 0;
    tick();
    idle();
    check("stats_br", br_count, 16'd3);
    check("stats_taken", taken_count, 16'd2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
